// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter device
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int ADDR_TXDATA = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_CLKDIV = 2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_LEVEL_LSB = 4;

    // STATUS only has a 4-bit level field, so deeper FIFOs report 15 when fuller.
    function automatic logic [3:0] sat_level(input logic [31:0] lvl);
        return (lvl > 32'd15) ? 4'hF : lvl[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - falling-edge synchronous FIFO with push-when-full-and-popping
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // A pop in the same edge frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(negedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(negedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_device.sv
// rtl/uart_tx_device.sv - bus-mapped UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_device
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    tx_state_t             state_q, state_nxt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
    logic [DATA_WIDTH-1:0] bit_cnt_q, cnt_nxt;
    logic [DATA_WIDTH-1:0] active_div_q, div_nxt;
    logic [BW-1:0]         bit_idx_q, idx_nxt;
    logic [DATA_WIDTH-1:0] clkdiv_q;
    logic                  overrun_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [7:0]            status;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q;
`endif

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LW-1:0]         fifo_level;
    logic [LW-1:0]         level_nxt;
    logic [DATA_WIDTH-1:0] fifo_dout;

    logic                  rd_access;
    logic                  wr_txdata;
    logic                  wr_clkdiv;
    logic                  rd_status;
    logic                  push_acc;
    logic                  overrun_evt;
    logic                  bit_end;
    logic                  start_frame;

    assign rd_access   = enable && mode;
    assign wr_txdata   = enable && !mode && (address == ADDR_WIDTH'(ADDR_TXDATA));
    assign wr_clkdiv   = enable && !mode && (address == ADDR_WIDTH'(ADDR_CLKDIV));
    assign rd_status   = rd_access && (address == ADDR_WIDTH'(ADDR_STATUS));
    assign push_acc    = wr_txdata && (!fifo_full || fifo_pop);
    assign overrun_evt = wr_txdata && fifo_full && !fifo_pop;
    assign bit_end     = (bit_cnt_q == '0);
    assign level_nxt   = fifo_level + LW'(push_acc) - LW'(fifo_pop);

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_txdata),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_nxt   = state_q;
        shift_nxt   = shift_q;
        cnt_nxt     = bit_cnt_q;
        div_nxt     = active_div_q;
        idx_nxt     = bit_idx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_frame = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = active_div_q;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = bit_cnt_q - DATA_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_nxt = active_div_q;
                    if (bit_idx_q == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        shift_nxt = shift_q >> 1;
                        idx_nxt   = bit_idx_q + BW'(1);
                    end
                end else begin
                    cnt_nxt = bit_cnt_q - DATA_WIDTH'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                    cnt_nxt   = active_div_q;
                end else begin
                    cnt_nxt = bit_cnt_q - DATA_WIDTH'(1);
                end
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit so queued frames are contiguous.
                if (bit_end) begin
                    state_nxt   = ST_IDLE;
                    start_frame = !fifo_empty;
                end else begin
                    cnt_nxt = bit_cnt_q - DATA_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (start_frame) begin
            fifo_pop  = 1'b1;
            state_nxt = ST_START;
            shift_nxt = fifo_dout;
            cnt_nxt   = clkdiv_q;
            div_nxt   = clkdiv_q;
        end
    end

    always_comb begin
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = parity_q;
`endif
            default:  tx = 1'b1;
        endcase
    end

    always_comb begin
        status                          = '0;
        status[STAT_FULL]               = fifo_full;
        status[STAT_EMPTY]              = fifo_empty;
        status[STAT_BUSY]               = (state_q != ST_IDLE);
        status[STAT_OVERRUN]            = overrun_q;
        status[STAT_LEVEL_LSB +: 4]     = sat_level(32'(fifo_level));
    end

    always_comb begin
        rd_val = '0;
        if (address == ADDR_WIDTH'(ADDR_STATUS)) begin
            rd_val = DATA_WIDTH'(status);
        end else if (address == ADDR_WIDTH'(ADDR_CLKDIV)) begin
            rd_val = clkdiv_q;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            active_div_q <= '0;
            bit_idx_q    <= '0;
            clkdiv_q     <= DATA_WIDTH'(DIV_RESET);
            overrun_q    <= 1'b0;
            rd_q         <= '0;
            tx_busy      <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            shift_q      <= shift_nxt;
            bit_cnt_q    <= cnt_nxt;
            active_div_q <= div_nxt;
            bit_idx_q    <= idx_nxt;
            tx_busy      <= (state_nxt != ST_IDLE) || (level_nxt != '0);
            if (wr_clkdiv) begin
                clkdiv_q <= data_in;
            end
            // The captured STATUS value still carries the overrun flag being cleared.
            if (rd_status) begin
                overrun_q <= 1'b0;
            end else if (overrun_evt) begin
                overrun_q <= 1'b1;
            end
            if (rd_access) begin
                rd_q <= rd_val;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(negedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (start_frame) begin
            parity_q <= ^fifo_dout;
        end
    end
`endif

    assign data_out = rd_access ? rd_q : 'z;

endmodule

// File: tb/tb_uart_tx_device.sv
// tb/tb_uart_tx_device.sv - directed scoreboard bench for uart_tx_device
module tb_uart_tx_device;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] address;
    logic       enable;
    logic       mode;
    logic [7:0] data_in;
    wire  [7:0] data_out;
    logic       tx;
    logic       tx_busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   mon_starts[$];
    int   mon_done = 0;
    bit   mon_en = 0;
    bit   mon_flush = 0;

    uart_tx_device dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .enable   (enable),
        .mode     (mode),
        .data_in  (data_in),
        .data_out (data_out),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expected_bits(input logic [7:0] d);
        logic [31:0] e;
        e      = '0;
        e[8:1] = d;
`ifdef UART_TX_PARITY_EN
        e[9]   = ^d;
        e[10]  = 1'b1;
`else
        e[9]   = 1'b1;
`endif
        return e;
    endfunction

    // Serial monitor: samples tx once per clock and checks every cycle of every bit.
    initial begin
        exp_t        cur;
        bit          active;
        int          cnt;
        logic [31:0] obits;
        bit          glitch;
        int          bi;
        int          pos;
        active = 0;
        cnt = 0;
        obits = '0;
        glitch = 0;
        cur.data = '0;
        cur.div = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_flush) begin
                active = 0;
                mon_flush = 0;
            end else if (mon_en) begin
                if (!active && tx === 1'b0) begin
                    check("frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                    end else begin
                        cur.data = '0;
                        cur.div = 0;
                    end
                    active = 1;
                    cnt = 0;
                    obits = '0;
                    glitch = 0;
                    mon_starts.push_back(cyc);
                end
                if (active) begin
                    bi  = cnt / (cur.div + 1);
                    pos = cnt % (cur.div + 1);
                    if (pos == 0) obits[bi] = tx;
                    else if (tx !== obits[bi]) glitch = 1;
                    cnt++;
                    if (cnt == NB * (cur.div + 1)) begin
                        check("frame_bits", obits, expected_bits(cur.data));
                        check("frame_bit_width", 32'(glitch), 32'd0);
                        active = 0;
                        mon_done++;
                    end
                end
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        enable = 1'b1;
        mode = 1'b0;
        address = a;
        data_in = d;
        @(negedge clk);
        #2;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(posedge clk);
        enable = 1'b1;
        mode = 1'b1;
        address = a;
        @(negedge clk);
        #2;
        d = data_out;
    endtask

    task automatic bus_idle();
        @(posedge clk);
        enable = 1'b0;
        mode = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (mon_done < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("frames_done", 32'(mon_done), 32'(target));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        int         base;
        int         done_before;
        rst = 1'b1;
        enable = 1'b0;
        mode = 1'b0;
        address = '0;
        data_in = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        @(posedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        mon_en = 1;
        bus_read(4'd1, rd);
        check("reset_status", 32'(rd), 32'h02);
        bus_read(4'd2, rd);
        check("reset_clkdiv", 32'(rd), 32'd15);
        bus_read(4'd0, rd);
        check("txdata_reads_zero", 32'(rd), 32'd0);
        bus_write(4'd5, 8'hFF);
        bus_read(4'd5, rd);
        check("unlisted_reads_zero", 32'(rd), 32'd0);

        // Single frame at divisor 3 with latency checks
        bus_write(4'd2, 8'd3);
        sb.push_back('{8'hA5, 3});
        bus_write(4'd0, 8'hA5);
        check("push_edge_tx_idle", 32'(tx), 32'd1);
        check("push_edge_busy", 32'(tx_busy), 32'd1);
        bus_idle();
        @(negedge clk);
        #2;
        check("start_next_edge", 32'(tx), 32'd0);
        wait_frames(1, 200);
        repeat (3) @(negedge clk);
        #2;
        check("idle_busy_low", 32'(tx_busy), 32'd0);

        // Overrun: six back-to-back writes into a depth-4 FIFO at divisor 0
        bus_write(4'd2, 8'd0);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back('{8'(8'h10 + i * 8'h11), 0});
            bus_write(4'd0, 8'(8'h10 + i * 8'h11));
        end
        bus_read(4'd1, rd);
        check("overrun_status", 32'(rd), 32'h4D);
        bus_read(4'd1, rd);
        check("overrun_cleared", 32'(rd), 32'h45);
        bus_idle();
        wait_frames(6, 400);

        // Two queued frames at divisor 3 are contiguous
        bus_write(4'd2, 8'd3);
        base = mon_starts.size();
        sb.push_back('{8'h3C, 3});
        bus_write(4'd0, 8'h3C);
        sb.push_back('{8'h81, 3});
        bus_write(4'd0, 8'h81);
        bus_read(4'd1, rd);
        check("midframe_status", 32'(rd), 32'h14);
        bus_idle();
        wait_frames(8, 300);
        if (mon_starts.size() >= base + 2)
            check("contiguous_frames", 32'(mon_starts[base+1] - mon_starts[base]), 32'(NB * 4));
        else
            check("contiguous_frames_seen", 32'(mon_starts.size()), 32'(base + 2));

        // Divisor change mid-frame applies only to the next frame
        sb.push_back('{8'h5A, 3});
        bus_write(4'd0, 8'h5A);
        bus_idle();
        repeat (6) @(negedge clk);
        bus_write(4'd2, 8'd7);
        sb.push_back('{8'hC3, 7});
        bus_write(4'd0, 8'hC3);
        bus_read(4'd2, rd);
        check("clkdiv_readback", 32'(rd), 32'd7);
        bus_idle();
        wait_frames(10, 400);

        // Reset mid-data-bit with bytes queued, colliding with a bus write
        sb.push_back('{8'hE7, 7});
        bus_write(4'd0, 8'hE7);
        bus_write(4'd0, 8'h42);
        bus_write(4'd0, 8'h99);
        bus_idle();
        repeat (12) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        enable = 1'b1;
        mode = 1'b0;
        address = 4'd0;
        data_in = 8'h77;
        sb.delete();
        mon_flush = 1;
        done_before = mon_done;
        @(negedge clk);
        #2;
        check("reset_abort_tx", 32'(tx), 32'd1);
        check("reset_abort_busy", 32'(tx_busy), 32'd0);
        @(posedge clk);
        rst = 1'b0;
        enable = 1'b0;
        bus_read(4'd1, rd);
        check("reset_abort_status", 32'(rd), 32'h02);
        bus_read(4'd2, rd);
        check("reset_abort_clkdiv", 32'(rd), 32'd15);
        bus_idle();
        repeat (300) @(negedge clk);
        #2;
        check("no_frames_after_reset", 32'(mon_done), 32'(done_before));
        check("tx_idle_after_reset", 32'(tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_device.md
# uart_tx_device

Memory-mapped serial transmitter on the 8-bit CPU device bus, the downstream consumer of bus writes for character output. The CPU writes bytes into a small transmit FIFO through the bus slave port, reads status back, and the block serializes each byte onto a single `tx` line as an asynchronous frame. It uses the same address/enable/mode/tristate bus protocol and falling-edge timing as the other bus devices.

## Interface
- `DATA_WIDTH`, 8: bus width and frame data bits.
- `ADDR_WIDTH`, 4: local register address width.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, at least 2.
- `DIV_RESET`, 15: reset value of CLKDIV.

- `clk` in 1: single clock. All state updates on the falling edge, matching the bus.
- `rst` in 1: synchronous, active-high reset, sampled on the same falling edge.
- `address` in ADDR_WIDTH: register select.
- `enable` in 1: bus access strobe.
- `mode` in 1: 1 = read, 0 = write.
- `data_in` in DATA_WIDTH: write data.
- `data_out` out DATA_WIDTH: read data. Driven only while `enable && mode`, otherwise `'z`.
- `tx` out 1: serial line, idle high.
- `tx_busy` out 1: high while a frame is in progress or the FIFO is non-empty.

## Operation
- Register map; unlisted addresses read 0 and ignore writes:
  - 0 TXDATA, write-only: push `data_in`. Reads return 0.
  - 1 STATUS, read-only:
    - bit0 full, bit1 empty, bit2 busy (frame active), bit3 overrun (sticky).
    - bits[7:4] FIFO level, saturating at 15.
  - 2 CLKDIV, read/write: bit period = CLKDIV+1 clocks.
- Read path: the read value is captured at the falling edge of an `enable && mode` cycle and held in a register. `data_out` drives that register while the access is active.
- A STATUS read clears overrun at the same edge. The captured value still shows overrun = 1.
- Push rule: a TXDATA write is accepted if the FIFO is not full, or if the FSM pops in the same edge.
  - A rejected write drops the data and sets overrun.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE → START when the FIFO is non-empty. Pop the head into the shift register and latch CLKDIV into the active divisor.
  - START → DATA after one bit period.
  - DATA shifts LSB first for DATA_WIDTH bit periods, then → STOP.
  - STOP → IDLE after one bit period. No idle gap is inserted if the FIFO is non-empty: IDLE → START occurs on the very next edge.
- `tx` levels: START = 0, DATA = current LSB, STOP = 1, IDLE = 1.
- The bit counter is a down-counter reloaded with the active divisor at each bit boundary.
- A CLKDIV write mid-frame does not affect the current frame. It applies from the next IDLE → START.
- Reset values:
  - `tx` = 1, `tx_busy` = 0, FIFO empty, overrun = 0, CLKDIV = DIV_RESET, FSM = IDLE.
  - Read register = 0, so `data_out` is `'z` unless a read is active.
- Reset mid-frame aborts the frame. `tx` is 1 after the reset edge and FIFO contents are discarded.
- Reset has priority over a simultaneous bus write.

## Timing
- A write to TXDATA at edge N with the FIFO empty and the FSM idle:
  - pushes at edge N;
  - pops at edge N+1, with `tx` = 0 from N+1;
  - the start bit spans CLKDIV+1 edges.
- Frame length: (DATA_WIDTH+2)·(CLKDIV+1) clocks, or (DATA_WIDTH+3)·(CLKDIV+1) with parity.
- STATUS reflects state after the previous edge. A push and a STATUS read in back-to-back cycles show the updated level.
- `tx_busy` is registered and updates at the same edge as the FIFO and FSM.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: a PARITY state sits between DATA and STOP and sends even parity (XOR of the data bits) for one bit period.
- Undefined: no PARITY state; DATA → STOP directly.

## Structure
- Package `uart_pkg`:
  - FSM state enum;
  - register address constants (ADDR_TXDATA = 0, ADDR_STATUS = 1, ADDR_CLKDIV = 2);
  - STATUS bit index constants.
- Sub-module `sync_fifo`:
  - parameterized width and depth, falling-edge clocked, synchronous reset;
  - push/pop/full/empty/level, with simultaneous push and pop when full permitted.

## Test plan
- Reset, then idle 20 clocks → `tx` = 1, `tx_busy` = 0, STATUS read = 0x02.
- CLKDIV = 3, write TXDATA = 0xA5 → `tx` sequence 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each bit exactly 4 clocks; with parity on, a 0 parity bit precedes stop.
- CLKDIV = 0, write 6 bytes back-to-back with FIFO_DEPTH 4 → exactly 5 bytes transmitted (the one popped at the first write's following edge frees a slot), the 6th dropped, and STATUS bit3 = 1 on the next read and 0 on the read after.
- Write 2 bytes, read STATUS mid-frame → level = 1, busy = 1; the frames are contiguous with no idle cycle between stop and the second start.
- Write CLKDIV = 7 during a frame at divisor 3 → the current frame keeps 4-clock bits and the next frame uses 8-clock bits.
- Assert `rst` mid-data-bit with 3 bytes queued → `tx` = 1 after the edge, STATUS = 0x02, CLKDIV reads DIV_RESET, and no further frames are sent.
